// File: rtl/ob_pkg.sv
// ob_pkg -- shared order-book types used by the table scheduler and its clients.
`default_nettype none

package ob_pkg;

  typedef logic [7:0]  uid_t;
  typedef logic [15:0] price_t;
  typedef logic [15:0] quantity_t;
  typedef logic [23:0] accum_quantity_t;

  typedef struct packed {
    uid_t      uid;
    price_t    price;
    quantity_t qty;
  } table_t;

endpackage

`default_nettype wire

// File: rtl/ob_tbl_sched_if.sv
// ob_tbl_sched_if -- request/response channels between order-book clients and the table scheduler.
`default_nettype none

interface ob_tbl_sched_if;

  logic                     ins_vld;
  ob_pkg::table_t           ins_tbl;
  logic                     ins_rdy;

  logic                     cxl_vld;
  ob_pkg::uid_t             cxl_uid;
  logic                     cxl_rdy;

  logic                     qry_vld;
  logic                     qry_rdy;

  logic                     cxl_rsp_vld;
  logic                     cxl_rsp_hit;
  ob_pkg::table_t           cxl_rsp_tbl;

  logic                     qry_rsp_vld;
  ob_pkg::accum_quantity_t  qry_rsp_qty;

  modport master (
    output ins_vld, ins_tbl, cxl_vld, cxl_uid, qry_vld,
    input  ins_rdy, cxl_rdy, qry_rdy,
    input  cxl_rsp_vld, cxl_rsp_hit, cxl_rsp_tbl, qry_rsp_vld, qry_rsp_qty
  );

  modport slave (
    input  ins_vld, ins_tbl, cxl_vld, cxl_uid, qry_vld,
    output ins_rdy, cxl_rdy, qry_rdy,
    output cxl_rsp_vld, cxl_rsp_hit, cxl_rsp_tbl, qry_rsp_vld, qry_rsp_qty
  );

endinterface

`default_nettype wire

// File: rtl/ob_tbl_sched.sv
// ob_tbl_sched -- arbitrates insert/cancel/quantity-query commands onto the order table,
// one per cycle, with starvation promotion for queries and registered responses.
`default_nettype none

module ob_tbl_sched #(
  parameter int STARVE_LIM = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  ob_tbl_sched_if.slave                 req,
  input  wire logic                     head_busy,
  output logic                          tbl_insert,
  output ob_pkg::table_t                tbl_insert_tbl,
  output logic                          tbl_cancel,
  output ob_pkg::uid_t                  tbl_cancel_uid,
  input  wire logic                     tbl_cancel_hit_w,
  input  ob_pkg::table_t                tbl_cancel_hit_tbl_w,
  input  wire logic                     tbl_full_w,
  output logic                          tbl_qry_vld,
  input  wire logic                     tbl_qry_rsp_vld_r,
  input  ob_pkg::accum_quantity_t       tbl_qry_rsp_qty_r
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_QWAIT = 1'b1;
  localparam logic [3:0] LIM     = 4'(STARVE_LIM);

  logic [0:0]               state_q, state_d;
  logic                     full_q;
  logic [3:0]               starve_q, starve_d;
  logic                     cxl_rsp_vld_q, cxl_rsp_hit_q;
  ob_pkg::table_t           cxl_rsp_tbl_q;
  logic                     qry_rsp_vld_q, qry_rsp_vld_d;
  ob_pkg::accum_quantity_t  qry_rsp_qty_q;

  logic open, starve, cxl_gnt, ins_gnt, qry_gnt;

  // Reset gates the grants so no requester sees ready while rst is held.
  always_comb begin
    open    = (state_q == S_IDLE) && !head_busy && !rst;
    starve  = (starve_q >= LIM) && req.qry_vld;
    cxl_gnt = open && req.cxl_vld && !starve;
    ins_gnt = open && req.ins_vld && !full_q && !req.cxl_vld && !starve;
    qry_gnt = open && req.qry_vld &&
              (starve || (!req.cxl_vld && !(req.ins_vld && !full_q)));
  end

  always_comb begin
    starve_d = starve_q;
    if (!req.qry_vld || qry_gnt) begin
      starve_d = 4'd0;
    end else if ((cxl_gnt || ins_gnt) && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // A table result seen outside QWAIT is stale and must not produce a response.
  always_comb begin
    state_d       = state_q;
    qry_rsp_vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (qry_gnt) state_d = S_QWAIT;
      end
      S_QWAIT: begin
        if (tbl_qry_rsp_vld_r) begin
          state_d       = S_IDLE;
          qry_rsp_vld_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      full_q        <= 1'b0;
      starve_q      <= 4'd0;
      cxl_rsp_vld_q <= 1'b0;
      cxl_rsp_hit_q <= 1'b0;
      cxl_rsp_tbl_q <= '0;
      qry_rsp_vld_q <= 1'b0;
      qry_rsp_qty_q <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= tbl_full_w;
      starve_q      <= starve_d;
      cxl_rsp_vld_q <= cxl_gnt;
      if (cxl_gnt) begin
        cxl_rsp_hit_q <= tbl_cancel_hit_w;
        cxl_rsp_tbl_q <= tbl_cancel_hit_w ? tbl_cancel_hit_tbl_w : '0;
      end
      qry_rsp_vld_q <= qry_rsp_vld_d;
      if (qry_rsp_vld_d) qry_rsp_qty_q <= tbl_qry_rsp_qty_r;
    end
  end

  assign req.cxl_rdy     = cxl_gnt;
  assign req.ins_rdy     = ins_gnt;
  assign req.qry_rdy     = qry_gnt;
  assign req.cxl_rsp_vld = cxl_rsp_vld_q;
  assign req.cxl_rsp_hit = cxl_rsp_hit_q;
  assign req.cxl_rsp_tbl = cxl_rsp_tbl_q;
  assign req.qry_rsp_vld = qry_rsp_vld_q;
  assign req.qry_rsp_qty = qry_rsp_qty_q;

  assign tbl_insert      = ins_gnt;
  assign tbl_insert_tbl  = req.ins_tbl;
  assign tbl_cancel      = cxl_gnt;
  assign tbl_cancel_uid  = req.cxl_uid;
  assign tbl_qry_vld     = qry_gnt;

endmodule

`default_nettype wire

// File: tb/tb_ob_tbl_sched.sv
// tb_ob_tbl_sched -- scenario tasks with scoreboard queues for cancel and query responses.
`default_nettype none

module tb_ob_tbl_sched;
  import ob_pkg::*;

  typedef struct packed {
    logic   hit;
    table_t tbl;
  } cxl_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ob_tbl_sched_if bus();

  logic            head_busy;
  logic            tbl_insert, tbl_cancel, tbl_qry_vld;
  table_t          tbl_insert_tbl;
  uid_t            tbl_cancel_uid;
  logic            tbl_cancel_hit_w;
  table_t          tbl_cancel_hit_tbl_w;
  logic            tbl_full_w;
  logic            tbl_qry_rsp_vld_r;
  accum_quantity_t tbl_qry_rsp_qty_r;

  int n_tests = 0;
  int n_fail  = 0;

  cxl_exp_t        cxl_sb[$];
  accum_quantity_t qry_sb[$];

  function automatic table_t mk_entry(uid_t u);
    table_t t;
    t.uid   = u;
    t.price = 16'h0100 + 16'(u);
    t.qty   = 16'(u) * 16'd3 + 16'd1;
    return t;
  endfunction

  // Table model: uids 0..15 are resident; the entry bus carries data even on a miss.
  assign tbl_cancel_hit_w     = (bus.cxl_uid <= 8'd15);
  assign tbl_cancel_hit_tbl_w = mk_entry(bus.cxl_uid);

  ob_tbl_sched #(.STARVE_LIM(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req                  (bus),
    .head_busy            (head_busy),
    .tbl_insert           (tbl_insert),
    .tbl_insert_tbl       (tbl_insert_tbl),
    .tbl_cancel           (tbl_cancel),
    .tbl_cancel_uid       (tbl_cancel_uid),
    .tbl_cancel_hit_w     (tbl_cancel_hit_w),
    .tbl_cancel_hit_tbl_w (tbl_cancel_hit_tbl_w),
    .tbl_full_w           (tbl_full_w),
    .tbl_qry_vld          (tbl_qry_vld),
    .tbl_qry_rsp_vld_r    (tbl_qry_rsp_vld_r),
    .tbl_qry_rsp_qty_r    (tbl_qry_rsp_qty_r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cxl(uid_t u);
    cxl_exp_t e;
    e.hit = (u <= 8'd15);
    e.tbl = e.hit ? mk_entry(u) : '0;
    cxl_sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ins_vld = 1'b1; bus.cxl_vld = 1'b1; bus.qry_vld = 1'b1;
    bus.ins_tbl = mk_entry(8'd1); bus.cxl_uid = 8'd1;
    @(negedge clk);
    n_tests++;
    if ({bus.ins_rdy, bus.cxl_rdy, bus.qry_rdy, tbl_insert, tbl_cancel, tbl_qry_vld} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_rdy got=%b exp=000000",
               {bus.ins_rdy, bus.cxl_rdy, bus.qry_rdy, tbl_insert, tbl_cancel, tbl_qry_vld});
    end
    n_tests++;
    if ({bus.cxl_rsp_vld, bus.cxl_rsp_hit, bus.cxl_rsp_tbl, bus.qry_rsp_vld, bus.qry_rsp_qty} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp got vld=%b hit=%b tbl=%h qvld=%b qty=%h exp all zero",
               bus.cxl_rsp_vld, bus.cxl_rsp_hit, bus.cxl_rsp_tbl, bus.qry_rsp_vld, bus.qry_rsp_qty);
    end
    bus.ins_vld = 1'b0; bus.cxl_vld = 1'b0; bus.qry_vld = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_cxl_over_ins();
    bus.ins_vld = 1'b1; bus.ins_tbl = mk_entry(8'd40);
    bus.cxl_vld = 1'b1; bus.cxl_uid = 8'd3;
    @(negedge clk);
    n_tests++;
    if ({bus.cxl_rdy, bus.ins_rdy, tbl_cancel, tbl_insert} !== 4'b1010 || tbl_cancel_uid !== 8'd3) begin
      n_fail++;
      $display("FAIL cxl_pri got cxl_rdy=%b ins_rdy=%b cancel=%b insert=%b uid=%0d exp 1,0,1,0,3",
               bus.cxl_rdy, bus.ins_rdy, tbl_cancel, tbl_insert, tbl_cancel_uid);
    end
    if (tbl_cancel) push_cxl(8'd3);
    step();
    bus.cxl_vld = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.ins_rdy !== 1'b1 || tbl_insert !== 1'b1 || tbl_insert_tbl !== mk_entry(8'd40)) begin
      n_fail++;
      $display("FAIL ins_next got rdy=%b insert=%b tbl=%h exp 1,1,%h",
               bus.ins_rdy, tbl_insert, tbl_insert_tbl, mk_entry(8'd40));
    end
    n_tests++;
    if (bus.cxl_rsp_vld !== 1'b1 || cxl_sb.size() == 0) begin
      n_fail++;
      $display("FAIL cxl_rsp_vld got=%b exp=1", bus.cxl_rsp_vld);
    end else begin
      cxl_exp_t e = cxl_sb.pop_front();
      if (bus.cxl_rsp_hit !== e.hit || bus.cxl_rsp_tbl !== e.tbl) begin
        n_fail++;
        $display("FAIL cxl_rsp_data got hit=%b tbl=%h exp hit=%b tbl=%h",
                 bus.cxl_rsp_hit, bus.cxl_rsp_tbl, e.hit, e.tbl);
      end
    end
    step();
    bus.ins_vld = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cxl_rsp_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL cxl_rsp_pulse got=%b exp=0", bus.cxl_rsp_vld);
    end
    step();
  endtask

  task automatic test_ins_over_qry();
    bus.ins_vld = 1'b1; bus.ins_tbl = mk_entry(8'd41); bus.qry_vld = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.ins_rdy, bus.qry_rdy, tbl_insert, tbl_qry_vld} !== 4'b1010) begin
      n_fail++;
      $display("FAIL ins_over_qry got ins_rdy=%b qry_rdy=%b insert=%b qry=%b exp 1,0,1,0",
               bus.ins_rdy, bus.qry_rdy, tbl_insert, tbl_qry_vld);
    end
    step();
    bus.ins_vld = 1'b0; bus.qry_vld = 1'b0;
    step();
  endtask

  task automatic test_cancel_miss();
    bus.cxl_vld = 1'b1; bus.cxl_uid = 8'd200;
    @(negedge clk);
    if (tbl_cancel) push_cxl(8'd200);
    step();
    bus.cxl_vld = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cxl_rsp_vld !== 1'b1 || cxl_sb.size() == 0) begin
      n_fail++;
      $display("FAIL miss_rsp_vld got=%b exp=1", bus.cxl_rsp_vld);
    end else begin
      cxl_exp_t e = cxl_sb.pop_front();
      if (bus.cxl_rsp_hit !== e.hit || bus.cxl_rsp_tbl !== e.tbl) begin
        n_fail++;
        $display("FAIL miss_rsp_data got hit=%b tbl=%h exp hit=%b tbl=%h",
                 bus.cxl_rsp_hit, bus.cxl_rsp_tbl, e.hit, e.tbl);
      end
    end
    step();
  endtask

  task automatic test_starve();
    int n_cxl = 0;
    int q_cyc = -1;
    int n_both = 0;
    bus.qry_vld = 1'b1; bus.cxl_vld = 1'b1;
    for (int i = 0; i < 12 && q_cyc < 0; i++) begin
      bus.cxl_uid = 8'(100 + i);
      @(negedge clk);
      if (tbl_cancel) n_cxl++;
      if (tbl_cancel && tbl_qry_vld) n_both++;
      if (tbl_qry_vld) q_cyc = i;
      step();
    end
    n_tests++;
    if (n_cxl != 8 || q_cyc != 8 || n_both != 0) begin
      n_fail++;
      $display("FAIL starve got cancels=%0d qry_cycle=%0d overlap=%0d exp 8,8,0", n_cxl, q_cyc, n_both);
    end
    bus.qry_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.cxl_rdy !== 1'b0 || tbl_cancel !== 1'b0) begin
        n_fail++;
        $display("FAIL qwait_stall got cxl_rdy=%b cancel=%b exp 0,0", bus.cxl_rdy, tbl_cancel);
      end
      step();
    end
    bus.cxl_vld = 1'b0;
    tbl_qry_rsp_vld_r = 1'b1; tbl_qry_rsp_qty_r = 24'h00002A;
    qry_sb.push_back(24'h00002A);
    step();
    tbl_qry_rsp_vld_r = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.qry_rsp_vld !== 1'b1 || qry_sb.size() == 0) begin
      n_fail++;
      $display("FAIL starve_qrsp got vld=%b exp=1", bus.qry_rsp_vld);
    end else begin
      accum_quantity_t q = qry_sb.pop_front();
      if (bus.qry_rsp_qty !== q) begin
        n_fail++;
        $display("FAIL starve_qty got=%h exp=%h", bus.qry_rsp_qty, q);
      end
    end
    step();
  endtask

  task automatic test_query();
    bit got = 1'b0;
    int lat = -1;
    bus.qry_vld = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.qry_rdy !== 1'b1 || tbl_qry_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL qry_issue got rdy=%b strobe=%b exp 1,1", bus.qry_rdy, tbl_qry_vld);
    end
    step();
    bus.qry_vld = 1'b0; bus.cxl_vld = 1'b1; bus.cxl_uid = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.cxl_rdy !== 1'b0 || bus.qry_rsp_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL qwait_idle got cxl_rdy=%b qrsp=%b exp 0,0", bus.cxl_rdy, bus.qry_rsp_vld);
      end
      step();
    end
    bus.cxl_vld = 1'b0;
    tbl_qry_rsp_vld_r = 1'b1; tbl_qry_rsp_qty_r = 24'h0001F4;
    qry_sb.push_back(24'h0001F4);
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      @(negedge clk);
      if (bus.qry_rsp_vld === 1'b1) begin
        got = 1'b1;
        lat = i;
        n_tests++;
        if (qry_sb.size() == 0) begin
          n_fail++;
          $display("FAIL qry_rsp_extra got qty=%h exp none", bus.qry_rsp_qty);
        end else begin
          accum_quantity_t q = qry_sb.pop_front();
          if (bus.qry_rsp_qty !== q || lat != 0) begin
            n_fail++;
            $display("FAIL qry_rsp got qty=%h lat=%0d exp qty=%h lat=0", bus.qry_rsp_qty, lat, q);
          end
        end
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL qry_rsp_timeout got no qry_rsp_vld exp pulse");
    end
    // Result strobe left high: must be treated as stale once back in IDLE.
    step();
    @(negedge clk);
    n_tests++;
    if (bus.qry_rsp_vld !== 1'b0 || bus.qry_rsp_qty !== 24'h0001F4) begin
      n_fail++;
      $display("FAIL qry_stale got vld=%b qty=%h exp 0,0001f4", bus.qry_rsp_vld, bus.qry_rsp_qty);
    end
    tbl_qry_rsp_vld_r = 1'b0;
    step();
    bus.cxl_vld = 1'b1; bus.cxl_uid = 8'd2;
    @(negedge clk);
    n_tests++;
    if (bus.cxl_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL qry_back_idle got cxl_rdy=%b exp=1", bus.cxl_rdy);
    end
    if (tbl_cancel) push_cxl(8'd2);
    step();
    bus.cxl_vld = 1'b0;
    @(negedge clk);
    if (bus.cxl_rsp_vld === 1'b1 && cxl_sb.size() != 0) void'(cxl_sb.pop_front());
    step();
  endtask

  task automatic test_full();
    tbl_full_w = 1'b1;
    step();
    bus.ins_vld = 1'b1; bus.ins_tbl = mk_entry(8'd50);
    @(negedge clk);
    n_tests++;
    if (bus.ins_rdy !== 1'b0 || tbl_insert !== 1'b0) begin
      n_fail++;
      $display("FAIL full_block got rdy=%b insert=%b exp 0,0", bus.ins_rdy, tbl_insert);
    end
    step();
    bus.cxl_vld = 1'b1; bus.cxl_uid = 8'd7;
    @(negedge clk);
    n_tests++;
    if (bus.cxl_rdy !== 1'b1 || tbl_cancel !== 1'b1) begin
      n_fail++;
      $display("FAIL full_cxl got rdy=%b cancel=%b exp 1,1", bus.cxl_rdy, tbl_cancel);
    end
    if (tbl_cancel) push_cxl(8'd7);
    step();
    bus.cxl_vld = 1'b0; tbl_full_w = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cxl_rsp_vld !== 1'b1 || cxl_sb.size() == 0) begin
      n_fail++;
      $display("FAIL full_cxl_rsp got vld=%b exp=1", bus.cxl_rsp_vld);
    end else begin
      cxl_exp_t e = cxl_sb.pop_front();
      if (bus.cxl_rsp_hit !== 1'b1 || bus.cxl_rsp_tbl.uid !== 8'd7 || bus.cxl_rsp_tbl !== e.tbl) begin
        n_fail++;
        $display("FAIL full_cxl_hit got hit=%b tbl=%h exp hit=1 tbl=%h",
                 bus.cxl_rsp_hit, bus.cxl_rsp_tbl, e.tbl);
      end
    end
    n_tests++;
    if (bus.ins_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_lag got ins_rdy=%b exp=0", bus.ins_rdy);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (bus.ins_rdy !== 1'b1 || tbl_insert !== 1'b1 || tbl_insert_tbl !== mk_entry(8'd50)) begin
      n_fail++;
      $display("FAIL full_release got rdy=%b insert=%b tbl=%h exp 1,1,%h",
               bus.ins_rdy, tbl_insert, tbl_insert_tbl, mk_entry(8'd50));
    end
    step();
    bus.ins_vld = 1'b0;
    step();
  endtask

  task automatic test_head_busy();
    head_busy = 1'b1;
    bus.ins_vld = 1'b1; bus.ins_tbl = mk_entry(8'd60);
    bus.cxl_vld = 1'b1; bus.cxl_uid = 8'd9; bus.qry_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.ins_rdy, bus.cxl_rdy, bus.qry_rdy, tbl_insert, tbl_cancel, tbl_qry_vld} !== 6'b0) begin
        n_fail++;
        $display("FAIL head_busy got=%b exp=000000",
                 {bus.ins_rdy, bus.cxl_rdy, bus.qry_rdy, tbl_insert, tbl_cancel, tbl_qry_vld});
      end
      step();
    end
    head_busy = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.cxl_rdy, bus.ins_rdy, bus.qry_rdy, tbl_cancel} !== 4'b1001) begin
      n_fail++;
      $display("FAIL head_free got cxl=%b ins=%b qry=%b cancel=%b exp 1,0,0,1",
               bus.cxl_rdy, bus.ins_rdy, bus.qry_rdy, tbl_cancel);
    end
    if (tbl_cancel) push_cxl(8'd9);
    step();
    bus.ins_vld = 1'b0; bus.cxl_vld = 1'b0; bus.qry_vld = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cxl_rsp_vld !== 1'b1 || cxl_sb.size() == 0) begin
      n_fail++;
      $display("FAIL head_cxl_rsp got vld=%b exp=1", bus.cxl_rsp_vld);
    end else begin
      cxl_exp_t e = cxl_sb.pop_front();
      if (bus.cxl_rsp_hit !== e.hit || bus.cxl_rsp_tbl !== e.tbl) begin
        n_fail++;
        $display("FAIL head_cxl_data got hit=%b tbl=%h exp hit=%b tbl=%h",
                 bus.cxl_rsp_hit, bus.cxl_rsp_tbl, e.hit, e.tbl);
      end
    end
    step();
  endtask

  task automatic test_reset_qwait();
    bus.qry_vld = 1'b1;
    @(negedge clk);
    n_tests++;
    if (tbl_qry_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL rq_issue got=%b exp=1", tbl_qry_vld);
    end
    step();
    bus.qry_vld = 1'b0;
    step();
    bus.cxl_vld = 1'b1; bus.cxl_uid = 8'd4;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.ins_rdy, bus.cxl_rdy, bus.qry_rdy, bus.qry_rsp_vld, bus.cxl_rsp_vld} !== 5'b0) begin
      n_fail++;
      $display("FAIL rq_in_reset got=%b exp=00000",
               {bus.ins_rdy, bus.cxl_rdy, bus.qry_rdy, bus.qry_rsp_vld, bus.cxl_rsp_vld});
    end
    step();
    rst = 1'b0; bus.cxl_vld = 1'b0;
    tbl_qry_rsp_vld_r = 1'b1; tbl_qry_rsp_qty_r = 24'h00004D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.qry_rsp_vld !== 1'b0 || bus.qry_rsp_qty !== 24'h0 ||
          bus.cxl_rsp_vld !== 1'b0 || bus.cxl_rsp_tbl !== '0) begin
        n_fail++;
        $display("FAIL rq_after got qvld=%b qty=%h cvld=%b ctbl=%h exp all zero",
                 bus.qry_rsp_vld, bus.qry_rsp_qty, bus.cxl_rsp_vld, bus.cxl_rsp_tbl);
      end
      step();
    end
    tbl_qry_rsp_vld_r = 1'b0;
    step();
  endtask

  initial begin
    head_busy = 1'b0; tbl_full_w = 1'b0;
    tbl_qry_rsp_vld_r = 1'b0; tbl_qry_rsp_qty_r = '0;
    bus.ins_vld = 1'b0; bus.ins_tbl = '0;
    bus.cxl_vld = 1'b0; bus.cxl_uid = '0; bus.qry_vld = 1'b0;

    test_reset();
    test_cxl_over_ins();
    test_ins_over_qry();
    test_cancel_miss();
    test_starve();
    test_query();
    test_full();
    test_head_busy();
    test_reset_qwait();

    n_tests++;
    if (cxl_sb.size() != 0 || qry_sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got cxl=%0d qry=%0d pending exp 0,0", cxl_sb.size(), qry_sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
